// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and screen constants for the sprite motion logic.
//   jump_state_t : vertical motion FSM state (IDLE / RISE / FALL)
//   GROUND_Y     : resting Y of the player sprite (screen Y grows downward)
//   CEIL_Y       : smallest Y the sprite may reach
//   SCREEN_H     : visible screen height in lines
//   sat_inc16    : saturating 16-bit increment
// -----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2
   } jump_state_t;

   localparam int SCREEN_H = 480;
   localparam int GROUND_Y = 400;
   localparam int CEIL_Y   = 0;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/jump_controller_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Rising-edge pulse generator for a level that is already synchronous to clk.
// The history flop resets to 0, so a level that is high when reset releases
// is seen as a fresh edge on the first sampling edge.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   din   : input level
//   pulse : high for the cycle in which din is 1 and was 0 at the last edge
// -----------------------------------------------------------------------------
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign pulse = din & ~prev_q;

endmodule

// File: rtl/jump_controller.sv
// -----------------------------------------------------------------------------
// jump_controller
// Per-frame vertical motion engine for the player sprite. A jump key press
// launches a rise/fall trajectory under constant gravity, clamped to the
// ceiling on the way up and to the ground on the way down. All motion
// updates happen on frame_tick; outputs move one cycle after the tick.
//
//   CLK        : system clock
//   RESET      : asynchronous active-low reset
//   frame_tick : one-cycle pulse per video frame
//   jump_req   : jump key level, synchronous to CLK
//   y_pos      : current sprite Y (registered)
//   airborne   : high in RISE or FALL; count enable for the frame counter
//   landed     : one-cycle pulse after the landing update
//   air_frames : frames since takeoff, saturating at 0xFFFF
//   state      : FSM state for debug
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | on the ground, waiting for a latched key press at a frame tick
// RISE  | moving up by vel each tick, vel shrinking by GRAVITY
// FALL  | moving down by vel each tick, vel growing up to MAX_FALL
// (3)   | unreachable; recovers to IDLE at GROUND_Y on the next tick
// -----------------------------------------------------------------------------
module jump_controller #(
   parameter int Y_W      = 10,
   parameter int GROUND_Y = game_pkg::GROUND_Y,
   parameter int CEIL_Y   = game_pkg::CEIL_Y,
   parameter int V0       = 12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 12
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic           frame_tick,
   input  logic           jump_req,
   output logic [Y_W-1:0] y_pos,
   output logic           airborne,
   output logic           landed,
   output logic [15:0]    air_frames,
   output logic [1:0]     state
);

   import game_pkg::*;

   // One extra bit for the ground compare, two for the signed ceiling compare.
   localparam int W1 = Y_W + 1;
   localparam int XW = Y_W + 2;

   localparam logic [Y_W-1:0] GROUND_V = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0] CEIL_V   = Y_W'(CEIL_Y);
   localparam logic [Y_W-1:0] V0_V     = Y_W'(V0);
   localparam logic [Y_W-1:0] GRAV_V   = Y_W'(GRAVITY);
   localparam logic [Y_W-1:0] MAXF_V   = Y_W'(MAX_FALL);
   localparam logic [W1-1:0]  GROUND_W = W1'(GROUND_Y);
   localparam logic [W1-1:0]  GRAV_W   = W1'(GRAVITY);
   localparam logic [W1-1:0]  MAXF_W   = W1'(MAX_FALL);

   jump_state_t    state_q,  state_d;
   logic [Y_W-1:0] y_q,      y_d;
   logic [Y_W-1:0] vel_q,    vel_d;
   logic [15:0]    air_q,    air_d;
   logic           landed_q, landed_d;
   logic           press_q,  press_d;

   logic                 key_edge;
   logic                 in_air;
   logic signed [XW-1:0] rise_diff;
   logic                 rise_clamp;
   logic [W1-1:0]        fall_sum;
   logic                 fall_land;
   logic [W1-1:0]        fall_vel_inc;

   edge_detect u_jump_edge (
      .clk   (CLK),
      .rst_n (RESET),
      .din   (jump_req),
      .pulse (key_edge)
   );

   assign in_air = (state_q == RISE) || (state_q == FALL);

   // Wide arithmetic so overshoot past the ceiling or ground is visible
   // before it can wrap in Y_W bits.
   always_comb begin
      rise_diff    = $signed({2'b00, y_q}) - $signed({2'b00, vel_q});
      rise_clamp   = rise_diff < $signed(XW'(CEIL_Y));
      fall_sum     = {1'b0, y_q} + {1'b0, vel_q};
      fall_land    = fall_sum >= GROUND_W;
      fall_vel_inc = {1'b0, vel_q} + GRAV_W;
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      vel_d    = vel_q;
      air_d    = air_q;
      landed_d = 1'b0;
      // Presses are only remembered on the ground: no double jump.
      press_d  = in_air ? 1'b0 : (press_q | key_edge);

      if (frame_tick) begin
         // Every tick consumes the latch, including an edge in this cycle.
         press_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (press_q || key_edge) begin
                  state_d = RISE;
                  vel_d   = V0_V;
                  air_d   = '0;
               end
            end
            RISE: begin
               air_d = sat_inc16(air_q);
               if (rise_clamp) begin
                  y_d     = CEIL_V;
                  vel_d   = '0;
                  state_d = FALL;
               end else begin
                  y_d = y_q - vel_q;
                  if (vel_q <= GRAV_V) begin
                     vel_d   = '0;
                     state_d = FALL;
                  end else begin
                     vel_d = vel_q - GRAV_V;
                  end
               end
            end
            FALL: begin
               air_d = sat_inc16(air_q);
               if (fall_land) begin
                  y_d      = GROUND_V;
                  vel_d    = '0;
                  state_d  = IDLE;
                  landed_d = 1'b1;
               end else begin
                  y_d   = fall_sum[Y_W-1:0];
                  vel_d = (fall_vel_inc > MAXF_W) ? MAXF_V : fall_vel_inc[Y_W-1:0];
               end
            end
            default: begin
               state_d = IDLE;
               y_d     = GROUND_V;
               vel_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         y_q      <= GROUND_V;
         vel_q    <= '0;
         air_q    <= '0;
         landed_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         vel_q    <= vel_d;
         air_q    <= air_d;
         landed_q <= landed_d;
         press_q  <= press_d;
      end
   end

   assign y_pos      = y_q;
   assign airborne   = in_air;
   assign landed     = landed_q;
   assign air_frames = air_q;
   assign state      = state_q;

endmodule

// File: tb/tb_jump_controller.sv
// -----------------------------------------------------------------------------
// tb_jump_controller
// Four jump_controller instances with different trajectories share one
// stimulus stream. A per-instance trajectory model is checked against every
// instance on every falling clock edge; directed sequences pin the model and
// the DUT to hand-computed trajectories, then a randomized run follows.
//   0: V0=4                         ground 400
//   1: V0=12                        ground 20 (ceiling clamp)
//   2: V0=2,  MAX_FALL=3            ground 400
//   3: V0=12, MAX_FALL=3            ground 400 (reaches terminal speed)
// -----------------------------------------------------------------------------
module tb_jump_controller;

   localparam int N = 4;
   localparam int P_V0   [N] = '{4, 12, 2, 12};
   localparam int P_GND  [N] = '{400, 20, 400, 400};
   localparam int P_MAXF [N] = '{12, 12, 3, 3};
   localparam int P_CEIL = 0;
   localparam int P_G    = 1;

   logic CLK        = 1'b0;
   logic RESET      = 1'b0;
   logic frame_tick = 1'b0;
   logic jump_req   = 1'b0;

   logic [9:0]  dut_y    [N];
   logic        dut_air  [N];
   logic        dut_land [N];
   logic [15:0] dut_fr   [N];
   logic [1:0]  dut_st   [N];

   jump_controller #(.Y_W(10), .GROUND_Y(400), .CEIL_Y(0), .V0(4), .GRAVITY(1), .MAX_FALL(12)) u_a (
      .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .jump_req(jump_req),
      .y_pos(dut_y[0]), .airborne(dut_air[0]), .landed(dut_land[0]),
      .air_frames(dut_fr[0]), .state(dut_st[0]));

   jump_controller #(.Y_W(10), .GROUND_Y(20), .CEIL_Y(0), .V0(12), .GRAVITY(1), .MAX_FALL(12)) u_c (
      .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .jump_req(jump_req),
      .y_pos(dut_y[1]), .airborne(dut_air[1]), .landed(dut_land[1]),
      .air_frames(dut_fr[1]), .state(dut_st[1]));

   jump_controller #(.Y_W(10), .GROUND_Y(400), .CEIL_Y(0), .V0(2), .GRAVITY(1), .MAX_FALL(3)) u_t (
      .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .jump_req(jump_req),
      .y_pos(dut_y[2]), .airborne(dut_air[2]), .landed(dut_land[2]),
      .air_frames(dut_fr[2]), .state(dut_st[2]));

   jump_controller #(.Y_W(10), .GROUND_Y(400), .CEIL_Y(0), .V0(12), .GRAVITY(1), .MAX_FALL(3)) u_m (
      .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .jump_req(jump_req),
      .y_pos(dut_y[3]), .airborne(dut_air[3]), .landed(dut_land[3]),
      .air_frames(dut_fr[3]), .state(dut_st[3]));

   always #5 CLK = ~CLK;

   int n_pass   = 0;
   int n_checks = 0;
   bit cmp_en   = 1'b0;
   int max_fall_step = 0;

   function automatic void chk(input string name, input int k, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
   endfunction

   // ---------------- trajectory model ----------------
   // phase: 0 on ground, 1 going up, 2 coming down (matches the debug encoding)
   int m_y    [N] = '{400, 20, 400, 400};
   int m_v    [N] = '{0, 0, 0, 0};
   int m_ph   [N] = '{0, 0, 0, 0};
   int m_fr   [N] = '{0, 0, 0, 0};
   bit m_land [N] = '{0, 0, 0, 0};
   bit m_pend [N] = '{0, 0, 0, 0};
   bit m_prev = 1'b0;

   always @(posedge CLK or negedge RESET) begin
      bit edge_seen;
      bit fired;
      if (!RESET) begin
         for (int k = 0; k < N; k++) begin
            m_y[k] = P_GND[k]; m_v[k] = 0; m_ph[k] = 0;
            m_fr[k] = 0; m_land[k] = 0; m_pend[k] = 0;
         end
         m_prev = 1'b0;
      end else begin
         edge_seen = jump_req && !m_prev;
         for (int k = 0; k < N; k++) begin
            m_land[k] = 0;
            if (!frame_tick) begin
               if (m_ph[k] == 0 && edge_seen) m_pend[k] = 1;
            end else begin
               fired = m_pend[k] || edge_seen;
               m_pend[k] = 0;
               if (m_ph[k] == 0) begin
                  if (fired) begin
                     m_ph[k] = 1; m_v[k] = P_V0[k]; m_fr[k] = 0;
                  end
               end else begin
                  m_fr[k] = (m_fr[k] < 65535) ? m_fr[k] + 1 : 65535;
                  if (m_ph[k] == 1) begin
                     if (m_y[k] - m_v[k] < P_CEIL) begin
                        m_y[k] = P_CEIL; m_v[k] = 0; m_ph[k] = 2;
                     end else begin
                        m_y[k] = m_y[k] - m_v[k];
                        m_v[k] = m_v[k] - P_G;
                        if (m_v[k] <= 0) begin m_v[k] = 0; m_ph[k] = 2; end
                     end
                  end else begin
                     if (m_y[k] + m_v[k] >= P_GND[k]) begin
                        m_y[k] = P_GND[k]; m_v[k] = 0; m_ph[k] = 0; m_land[k] = 1;
                     end else begin
                        m_y[k] = m_y[k] + m_v[k];
                        m_v[k] = (m_v[k] + P_G > P_MAXF[k]) ? P_MAXF[k] : m_v[k] + P_G;
                     end
                  end
               end
            end
         end
         m_prev = jump_req;
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         for (int k = 0; k < N; k++) begin
            chk("y_pos",      k, int'(dut_y[k]),    m_y[k]);
            chk("state",      k, int'(dut_st[k]),   m_ph[k]);
            chk("airborne",   k, int'(dut_air[k]),  (m_ph[k] != 0) ? 1 : 0);
            chk("landed",     k, int'(dut_land[k]), int'(m_land[k]));
            chk("air_frames", k, int'(dut_fr[k]),   m_fr[k]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      frame_tick = 1'b1;
      @(posedge CLK); #1;
      frame_tick = 1'b0;
   endtask

   task automatic press();
      jump_req = 1'b1;
      @(posedge CLK); #1;
      jump_req = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic settle();
      int guard;
      int step;
      int yb [N];
      logic [1:0] sb [N];
      guard = 0;
      while ((dut_air[0] || dut_air[1] || dut_air[2] || dut_air[3]) && guard < 200) begin
         for (int k = 0; k < N; k++) begin yb[k] = int'(dut_y[k]); sb[k] = dut_st[k]; end
         tick();
         guard++;
         for (int k = 2; k < N; k++) begin
            if (sb[k] == 2'd2) begin
               step = int'(dut_y[k]) - yb[k];
               chk("fall_step_le_3", k, (step <= 3) ? 1 : 0, 1);
               if (step > max_fall_step) max_fall_step = step;
            end
         end
      end
      chk("settle_bound", 0, (guard < 200) ? 1 : 0, 1);
   endtask

   int basic_seq [9] = '{396, 393, 391, 390, 390, 391, 393, 396, 400};
   int ceil_seq  [9] = '{8, 0, 0, 1, 3, 6, 10, 15, 20};

   initial begin
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b1;
      cmp_en = 1'b1;

      // reset values
      for (int k = 0; k < N; k++) begin
         chk("rst_y",     k, int'(dut_y[k]),   P_GND[k]);
         chk("rst_state", k, int'(dut_st[k]),  0);
         chk("rst_air",   k, int'(dut_air[k]), 0);
         chk("rst_frames",k, int'(dut_fr[k]),  0);
      end

      // basic jump (instance 0) alongside ceiling clamp (instance 1)
      press();
      tick();
      chk("takeoff_y",     0, int'(dut_y[0]),  400);
      chk("takeoff_state", 0, int'(dut_st[0]), 1);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("basic_y",       0, int'(dut_y[0]), basic_seq[i]);
         chk("model_basic_y", 0, m_y[0],         basic_seq[i]);
         chk("ceil_y",        1, int'(dut_y[1]), ceil_seq[i]);
         chk("model_ceil_y",  1, m_y[1],         ceil_seq[i]);
         if (i == 3) chk("fall_after_t4", 0, int'(dut_st[0]), 2);
         if (i == 1) chk("ceil_clamp_st", 1, int'(dut_st[1]), 2);
      end
      chk("basic_landed", 0, int'(dut_land[0]), 1);
      chk("basic_air",    0, int'(dut_air[0]),  0);
      chk("basic_frames", 0, int'(dut_fr[0]),   9);
      chk("ceil_landed",  1, int'(dut_land[1]), 1);
      @(posedge CLK); #1;
      chk("landed_pulse_1cyc", 0, int'(dut_land[0]), 0);
      settle();
      chk("terminal_reached", 3, max_fall_step, 3);

      // held key: one jump only
      jump_req = 1'b1;
      @(posedge CLK); #1;
      tick();
      for (int i = 0; i < 9; i++) tick();
      chk("held_landed", 0, int'(dut_land[0]), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("held_y",     0, int'(dut_y[0]),  400);
         chk("held_state", 0, int'(dut_st[0]), 0);
      end
      settle();
      jump_req = 1'b0;
      @(posedge CLK); #1;

      // mid-air press has no effect on the trajectory
      press();
      tick();
      for (int i = 0; i < 9; i++) begin
         if (i == 1) press();
         tick();
         chk("midair_y", 0, int'(dut_y[0]), basic_seq[i]);
      end
      chk("midair_frames", 0, int'(dut_fr[0]), 9);
      settle();

      // asynchronous reset in the middle of a rise
      press();
      tick();
      tick();
      tick();
      chk("pre_reset_y", 0, int'(dut_y[0]), 393);
      #3 RESET = 1'b0;
      #1;
      chk("async_rst_y",     0, int'(dut_y[0]),   400);
      chk("async_rst_state", 0, int'(dut_st[0]),  0);
      chk("async_rst_air",   0, int'(dut_air[0]), 0);
      chk("async_rst_y",     3, int'(dut_y[3]),   400);
      #2 RESET = 1'b1;
      @(posedge CLK); #1;
      press();
      tick();
      for (int i = 0; i < 9; i++) tick();
      chk("post_rst_y",      0, int'(dut_y[0]),    400);
      chk("post_rst_frames", 0, int'(dut_fr[0]),   9);
      chk("post_rst_landed", 0, int'(dut_land[0]), 1);
      settle();

      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         frame_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) jump_req = ~jump_req;
         if ($urandom_range(0, 799) == 0) begin
            #3 RESET = 1'b0;
            #2 RESET = 1'b1;
         end
         @(posedge CLK); #1;
      end
      frame_tick = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jump_controller.md
Name: jump_controller

Overview:
- Per-frame vertical motion engine for the player sprite.
- Sits upstream of the frame counter: its `airborne` output drives that counter's count enable, and its `air_frames` output gives a bounded jump duration.
- Converts a jump key into a rise/fall trajectory under constant gravity, clamped at ceiling and ground.
- `y_pos` goes directly to the sprite/drawing logic.

Parameters:
- Y_W, 10, width of the Y coordinate and velocity magnitude.
- GROUND_Y, 400, resting Y (screen Y grows downward).
- CEIL_Y, 0, minimum Y allowed.
- V0, 12, initial upward speed in px/frame.
- GRAVITY, 1, speed change per frame.
- MAX_FALL, 12, terminal downward speed in px/frame.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-low reset
- frame_tick  input  1  one-cycle pulse per video frame (vsync-derived)
- jump_req  input  1  jump key level, already synchronous to CLK
- y_pos  output  Y_W  current sprite Y, registered
- airborne  output  1  high in RISE or FALL; count enable for the downstream frame counter
- landed  output  1  one-cycle pulse on the landing update
- air_frames  output  16  frames since takeoff, saturating
- state  output  2  FSM state, for debug

Behaviour:
- Reset values (RESET low, asynchronous): state=IDLE, y_pos=GROUND_Y, vel=0, airborne=0, landed=0, air_frames=0, press latch=0, jump_req history=0.
- Edge detect: a rising edge of jump_req (0 then 1 on consecutive CLK samples) sets a press latch.
- The press latch clears on every frame_tick.
- Holding the key never retriggers a jump.
- An edge coinciding with a frame_tick is consumed by that tick.
- Update timing: all state, position and velocity updates happen only on frame_tick. Outputs change the cycle after frame_tick (1-cycle latency). With no tick, everything holds.
- Velocity: unsigned magnitude `vel` [Y_W-1:0]; direction is implied by state.
- IDLE:
  - If the press latch is set (or an edge is seen this cycle): go to RISE, vel=V0, air_frames=0.
  - y_pos is unchanged on the takeoff tick.
- RISE:
  - y_next = y_pos - vel.
  - If y_pos - vel < CEIL_Y (compute in Y_W+1 bits, signed): y_pos=CEIL_Y, vel=0, go to FALL.
  - Otherwise: y_pos=y_next, vel=vel-GRAVITY. If the result is <= 0: vel=0, go to FALL.
- FALL:
  - If y_pos + vel >= GROUND_Y (Y_W+1-bit compare): y_pos=GROUND_Y, vel=0, go to IDLE, landed=1 for exactly one cycle.
  - Otherwise: y_pos += vel, then vel = min(vel+GRAVITY, MAX_FALL).
- air_frames: increments on every tick spent in RISE or FALL, including the landing tick. Saturates at 0xFFFF.
- Press latch while airborne: cleared and ignored (no double jump).
- Reset mid-jump: returns immediately to IDLE at GROUND_Y.
- Invariant: CEIL_Y <= y_pos <= GROUND_Y always.
- Encoding: state IDLE=0, RISE=1, FALL=2; 3 is illegal and recovers to IDLE at GROUND_Y on the next tick.

Decomposition:
- Package `game_pkg`:
  - typedef enum `jump_state_t` {IDLE, RISE, FALL}.
  - Shared constants GROUND_Y, CEIL_Y, and the screen height.
- Sub-module `edge_detect`: rising-edge pulse generator. It is reusable for the other key inputs.
- FSM, velocity and position arithmetic stay in this module.

Test Plan (V0=4, GRAVITY=1, GROUND_Y=400 unless noted):
- Basic jump: press once, then 9 ticks.
  - y_pos sequence: 396, 393, 391, 390, 390, 391, 393, 396, 400.
  - State goes to FALL after tick 4.
  - landed pulses once after tick 9; airborne drops; air_frames=9.
- Held key: hold jump_req high through a landing and 5 more ticks -> no second jump; y_pos stays 400.
- Mid-air press: new edge at tick 2 -> trajectory identical to the basic jump; air_frames=9.
- Ceiling clamp: V0=12, GROUND_Y=20, CEIL_Y=0.
  - Tick 1: 20-12=8. Tick 2: 8-11 < 0, so y_pos clamps to 0, state=FALL, vel=0.
  - Then 0, 1, 3, 6, 10, 15, then 20 with landed pulse.
- Terminal velocity: V0=2, MAX_FALL=3, GROUND_Y=400.
  - Fall increments never exceed 3 px/tick.
- Async reset: assert RESET low mid-RISE without a CLK edge -> y_pos=400, state=IDLE, airborne=0 immediately. Release, then press -> a normal jump.
